mem_wb_stage: RTL and testbench

- Parametrised successor of the single-cycle MEM/WB stage.
- Owns a word-organised data RAM.
- Resolves branches and jumps.
- Formats sub-word loads and stores.
- Registers the write-back result behind a valid/ready handshake, so the pipeline can stall on multi-cycle RAM latency and on downstream back-pressure.
- Sits between EX/MEM and the register file / PC-select logic.

---
 rtl/mem_wb_stage_if.sv | 41 ++++
 rtl/mem_wb_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Handshake and data bundle between EX/MEM, the MEM/WB stage and write-back.
// "slave" is the stage itself; "master" is the surrounding pipeline.
interface mem_wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_alu_res;
  logic [XLEN-1:0]   in_store_data;
  logic [2:0]        in_jump_type;
  logic              in_reg_wr;
  logic              in_mem_wr;
  logic              in_mem_to_reg;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [REG_W-1:0]  in_write_reg;
  logic              out_valid;
  logic              out_ready;
  logic              out_reg_wr;
  logic [REG_W-1:0]  out_write_reg;
  logic [XLEN-1:0]   out_write_data;
  logic              should_jump;
  logic              out_misalign;

  modport master (
    output in_valid, in_alu_res, in_store_data, in_jump_type, in_reg_wr,
           in_mem_wr, in_mem_to_reg, in_size, in_unsigned, in_write_reg,
           out_ready,
    input  in_ready, out_valid, out_reg_wr, out_write_reg, out_write_data,
           should_jump, out_misalign
  );

  modport slave (
    input  in_valid, in_alu_res, in_store_data, in_jump_type, in_reg_wr,
           in_mem_wr, in_mem_to_reg, in_size, in_unsigned, in_write_reg,
           out_ready,
    output in_ready, out_valid, out_reg_wr, out_write_reg, out_write_data,
           should_jump, out_misalign
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: word-organised data RAM with sub-word load/store formatting,
// branch/jump resolution and a registered write-back result behind a
// valid/ready handshake. Loads wait MEM_LAT cycles before the result shows.
module mem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_wb_stage_if.slave bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic              ready_c, accept, capture;

  logic [XLEN-1:0]   ram [DEPTH];
  logic [XLEN-1:0]   rd_word_p0;
  logic [1:0]        ld_off_p0, ld_size_p0;
  logic              ld_uns_p0, ld_mis_p0;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              is_mem, mis;
  logic [3:0]        be;
  logic [XLEN-1:0]   wdata;

  logic              reg_wr_q, jump_q, mis_q;
  logic [REG_W-1:0]  write_reg_q;
  logic [XLEN-1:0]   write_data_q;

  // Half accesses need an even offset, word accesses offset 0; size 11 is a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] o);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return o[0];
      default: return o != 2'b00;
    endcase
  endfunction

  function automatic logic jump_taken(input logic [2:0] jt, input logic [XLEN-1:0] res);
    if (jt[2]) return jt[1] ? (res != '0) : (res == '0);
    return jt[0];
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] word,
                                                  input logic [1:0] o,
                                                  input logic [1:0] size,
                                                  input logic uns,
                                                  input logic bad);
    logic [XLEN-1:0] sh;
    sh = word >> {o, 3'b000};
    if (bad) return '0;
    case (size)
      2'b00:   return uns ? {{(XLEN-8){1'b0}}, sh[7:0]}   : {{(XLEN-8){sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {{(XLEN-16){1'b0}}, sh[15:0]} : {{(XLEN-16){sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign idx    = bus.in_alu_res[ADDR_W+1:2];
  assign off    = bus.in_alu_res[1:0];
  assign is_mem = bus.in_mem_wr | bus.in_mem_to_reg;
  assign mis    = is_mem & misaligned(bus.in_size, off);

  // Byte-lane enables and lane-replicated store data for the RAM write.
  always_comb begin
    be    = 4'b1111;
    wdata = bus.in_store_data;
    case (bus.in_size)
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{bus.in_store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << off;
        wdata = {2{bus.in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, acceptance and load-capture strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_c   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = bus.in_mem_to_reg ? WAIT : HOLD;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      HOLD: begin
        ready_c = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            state_nxt = bus.in_mem_to_reg ? WAIT : HOLD;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // No op is taken while reset is asserted, so reset can never corrupt the RAM.
  assign bus.in_ready = ready_c & reset_n;
  assign accept       = bus.in_valid & bus.in_ready;

  // RAM write on the acceptance edge and load word/format capture (stage 0).
  always_ff @(posedge clk) begin
    if (accept && bus.in_mem_wr && !mis) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (accept && bus.in_mem_to_reg) begin
      rd_word_p0 <= ram[idx];
      ld_off_p0  <= off;
      ld_size_p0 <= bus.in_size;
      ld_uns_p0  <= bus.in_unsigned;
      ld_mis_p0  <= mis;
    end
  end

  // Write-back result registers; held stable while HOLD waits on out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_wr_q     <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      jump_q       <= 1'b0;
      mis_q        <= 1'b0;
    end else if (accept) begin
      reg_wr_q    <= bus.in_reg_wr & ~(bus.in_mem_to_reg & mis);
      write_reg_q <= bus.in_write_reg;
      jump_q      <= jump_taken(bus.in_jump_type, bus.in_alu_res);
      mis_q       <= mis;
      if (!bus.in_mem_to_reg) write_data_q <= bus.in_alu_res;
    end else if (capture) begin
      write_data_q <= format_load(rd_word_p0, ld_off_p0, ld_size_p0, ld_uns_p0, ld_mis_p0);
    end
  end

  assign bus.out_valid      = (state == HOLD);
  assign bus.out_reg_wr     = reg_wr_q;
  assign bus.out_write_reg  = write_reg_q;
  assign bus.out_write_data = write_data_q;
  assign bus.should_jump    = jump_q;
  assign bus.out_misalign   = mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, reset and back-pressure
// sequences, then random ops checked against a byte-addressed memory model.
module tb_mem_wb_stage;
  localparam int XLEN = 32, ADDR_W = 8, REG_W = 5, MEM_LAT = 3;
  localparam int MEM_BYTES = 4 * (1 << ADDR_W);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(XLEN), .REG_W(REG_W)) bus();

  mem_wb_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_W(REG_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic [31:0] alu; logic [31:0] sd; logic [2:0] jt;
    logic reg_wr; logic mem_wr; logic ld; logic [1:0] size; logic uns; logic [4:0] wr;
  } op_t;
  typedef struct {
    logic reg_wr; logic [4:0] wr; logic [31:0] data; logic jump; logic mis; int lat;
  } res_t;
  typedef struct { string name; op_t op; res_t exp; } vec_t;

  int n_cmp = 0, n_fail = 0;
  byte unsigned mem_m [MEM_BYTES];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] jt,
                             input logic reg_wr, input logic mem_wr, input logic ld,
                             input logic [1:0] size, input logic uns, input logic [4:0] wr);
    op_t o;
    o.alu = alu; o.sd = sd; o.jt = jt; o.reg_wr = reg_wr; o.mem_wr = mem_wr;
    o.ld = ld; o.size = size; o.uns = uns; o.wr = wr;
    return o;
  endfunction

  function automatic res_t mkr(input logic reg_wr, input logic [4:0] wr, input logic [31:0] data,
                               input logic jump, input logic mis, input int lat);
    res_t r;
    r.reg_wr = reg_wr; r.wr = wr; r.data = data; r.jump = jump; r.mis = mis; r.lat = lat;
    return r;
  endfunction

  // Reference: byte-addressed memory, access width in bytes, arithmetic sign extension.
  task automatic model(input op_t op, output res_t r);
    int addr, n;
    bit memop, bad;
    longint v;
    addr  = int'(op.alu % MEM_BYTES);
    n     = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
    memop = op.mem_wr || op.ld;
    bad   = memop && (addr % n != 0);
    r.wr     = op.wr;
    r.jump   = op.jt[2] ? (op.jt[1] ? (op.alu != 0) : (op.alu == 0)) : op.jt[0];
    r.mis    = bad;
    r.reg_wr = op.reg_wr && !(op.ld && bad);
    r.lat    = op.ld ? MEM_LAT + 1 : 1;
    r.data   = op.alu;
    if (op.mem_wr && !bad)
      for (int i = 0; i < n; i++) mem_m[addr + i] = 8'(op.sd >> (8 * i));
    if (op.ld) begin
      if (bad) r.data = 32'd0;
      else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(mem_m[addr + i]) << (8 * i));
        if (!op.uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        r.data = v[31:0];
      end
    end
  endtask

  task automatic drive(input op_t op);
    bus.in_alu_res    = op.alu;
    bus.in_store_data = op.sd;
    bus.in_jump_type  = op.jt;
    bus.in_reg_wr     = op.reg_wr;
    bus.in_mem_wr     = op.mem_wr;
    bus.in_mem_to_reg = op.ld;
    bus.in_size       = op.size;
    bus.in_unsigned   = op.uns;
    bus.in_write_reg  = op.wr;
  endtask

  // One op from an idle stage: offer, wait for acceptance, wait for the result,
  // optionally stall the consumer, then release it.
  task automatic run_op(input op_t op, input int stall, output res_t r);
    int k;
    @(negedge clk);
    drive(op);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    k = 0;
    while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 1;
    while (!bus.out_valid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("valid_timeout", 32'd0, 32'd1);
    r.lat = k; r.reg_wr = bus.out_reg_wr; r.wr = bus.out_write_reg;
    r.data = bus.out_write_data; r.jump = bus.should_jump; r.mis = bus.out_misalign;
    for (int s = 0; s < stall; s++) @(negedge clk);
    chk("hold_stable", bus.out_write_data, r.data);
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    chk({tag, "_data"},   a.data, e.data);
    chk({tag, "_regwr"},  32'(a.reg_wr), 32'(e.reg_wr));
    chk({tag, "_wreg"},   32'(a.wr), 32'(e.wr));
    chk({tag, "_jump"},   32'(a.jump), 32'(e.jump));
    chk({tag, "_mis"},    32'(a.mis), 32'(e.mis));
    chk({tag, "_lat"},    32'(a.lat), 32'(e.lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  tbl [17];
    res_t  r, m;
    op_t   op;
    logic [31:0] bp_vals [4];
    logic [31:0] got_q [$];
    int cyc, sent;
    bit bp_bad, rst_bad;

    tbl[0]  = '{"st_word",    mk(32'h10, 32'hDEADBEEF, 3'b000, 0, 1, 0, 2'd2, 0, 5'd0),  mkr(0, 5'd0,  32'h10,       0, 0, 1)};
    tbl[1]  = '{"lb_s",       mk(32'h11, 32'h0,        3'b000, 1, 0, 1, 2'd0, 0, 5'd5),  mkr(1, 5'd5,  32'hFFFFFFBE, 0, 0, 4)};
    tbl[2]  = '{"lb_u",       mk(32'h11, 32'h0,        3'b000, 1, 0, 1, 2'd0, 1, 5'd5),  mkr(1, 5'd5,  32'h000000BE, 0, 0, 4)};
    tbl[3]  = '{"lh_s",       mk(32'h12, 32'h0,        3'b000, 1, 0, 1, 2'd1, 0, 5'd6),  mkr(1, 5'd6,  32'hFFFFDEAD, 0, 0, 4)};
    tbl[4]  = '{"st_byte",    mk(32'h13, 32'h55,       3'b000, 0, 1, 0, 2'd0, 0, 5'd0),  mkr(0, 5'd0,  32'h13,       0, 0, 1)};
    tbl[5]  = '{"lw_merge",   mk(32'h10, 32'h0,        3'b000, 1, 0, 1, 2'd2, 0, 5'd7),  mkr(1, 5'd7,  32'h55ADBEEF, 0, 0, 4)};
    tbl[6]  = '{"lw_wrap_s3", mk(32'h410, 32'h0,       3'b000, 1, 0, 1, 2'd3, 0, 5'd8),  mkr(1, 5'd8,  32'h55ADBEEF, 0, 0, 4)};
    tbl[7]  = '{"beq_taken",  mk(32'h0, 32'h0,         3'b100, 0, 0, 0, 2'd0, 0, 5'd0),  mkr(0, 5'd0,  32'h0,        1, 0, 1)};
    tbl[8]  = '{"bne_zero",   mk(32'h0, 32'h0,         3'b110, 0, 0, 0, 2'd0, 0, 5'd0),  mkr(0, 5'd0,  32'h0,        0, 0, 1)};
    tbl[9]  = '{"bne_seven",  mk(32'h7, 32'h0,         3'b110, 0, 0, 0, 2'd0, 0, 5'd0),  mkr(0, 5'd0,  32'h7,        1, 0, 1)};
    tbl[10] = '{"jump",       mk(32'h40, 32'h0,        3'b001, 1, 0, 0, 2'd0, 0, 5'd1),  mkr(1, 5'd1,  32'h40,       1, 0, 1)};
    tbl[11] = '{"st_w20",     mk(32'h20, 32'hCAFEF00D, 3'b000, 0, 1, 0, 2'd2, 0, 5'd0),  mkr(0, 5'd0,  32'h20,       0, 0, 1)};
    tbl[12] = '{"st_mis",     mk(32'h21, 32'h12345678, 3'b000, 0, 1, 0, 2'd2, 0, 5'd0),  mkr(0, 5'd0,  32'h21,       0, 1, 1)};
    tbl[13] = '{"lw_w20",     mk(32'h20, 32'h0,        3'b000, 1, 0, 1, 2'd2, 0, 5'd2),  mkr(1, 5'd2,  32'hCAFEF00D, 0, 0, 4)};
    tbl[14] = '{"lh_mis",     mk(32'h23, 32'h0,        3'b000, 1, 0, 1, 2'd1, 0, 5'd9),  mkr(0, 5'd9,  32'h0,        0, 1, 4)};
    tbl[15] = '{"alu",        mk(32'hA5A50001, 32'h0,  3'b000, 1, 0, 0, 2'd0, 0, 5'd31), mkr(1, 5'd31, 32'hA5A50001, 0, 0, 1)};
    tbl[16] = '{"jt_010",     mk(32'h0, 32'h0,         3'b010, 0, 0, 0, 2'd0, 0, 5'd0),  mkr(0, 5'd0,  32'h0,        0, 0, 1)};

    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(mk(32'h0, 32'h0, 3'b000, 0, 0, 0, 2'd0, 0, 5'd0));
    repeat (2) @(negedge clk);
    chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",   32'(bus.in_ready), 32'd0);
    chk("rst_data",       bus.out_write_data, 32'd0);
    chk("rst_regwr",      32'(bus.out_reg_wr), 32'd0);
    chk("rst_jump",       32'(bus.should_jump), 32'd0);
    chk("rst_mis",        32'(bus.out_misalign), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready",   32'(bus.in_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      model(tbl[i].op, m);
      run_op(tbl[i].op, i % 3, r);
      cmp_res(tbl[i].name, r, tbl[i].exp);
    end

    // Reset in the middle of a load: the load must vanish, the RAM must not.
    @(negedge clk);
    drive(mk(32'h10, 32'h0, 3'b000, 1, 0, 1, 2'd2, 0, 5'd4));
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) rst_bad = 1'b1;
    end
    chk("midrst_no_stale", 32'(rst_bad), 32'd0);
    bus.out_ready = 1'b0;
    op = mk(32'h10, 32'h0, 3'b000, 1, 0, 1, 2'd2, 0, 5'd4);
    model(op, m);
    run_op(op, 0, r);
    cmp_res("after_rst", r, m);

    // Back-pressure stream of ALU ops with out_ready pattern 1,0,0,1,...
    bp_vals[0] = 32'h11111111; bp_vals[1] = 32'h22222222;
    bp_vals[2] = 32'h33333333; bp_vals[3] = 32'h44444444;
    sent = 0; cyc = 0; bp_bad = 1'b0;
    while (got_q.size() < 4 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 4) begin
        drive(mk(bp_vals[sent], 32'h0, 3'b000, 1, 0, 0, 2'd0, 0, 5'(sent + 10)));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready && bus.in_ready) bp_bad = 1'b1;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_write_data);
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) bp_bad = 1'b1;
    end
    bus.out_ready = 1'b0;
    chk("bp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_order%0d", i), (i < got_q.size()) ? got_q[i] : 32'hXXXXXXXX, bp_vals[i]);
    chk("bp_ready_flag", 32'(bp_bad), 32'd0);

    // Fill the whole RAM so random loads read defined data.
    for (int w = 0; w < (1 << ADDR_W); w++) begin
      op = mk(32'(w * 4), $urandom, 3'b000, 0, 1, 0, 2'd2, 0, 5'd0);
      model(op, m);
      run_op(op, 0, r);
      cmp_res("fill", r, m);
    end

    // Random mix of ALU, branch, store and load ops.
    for (int t = 0; t < 300; t++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      op = mk(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom, 3'b000,
              1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom), 5'($urandom));
      case (kind)
        0: begin op.reg_wr = 1'b1; op.jt = 3'($urandom_range(0, 1)); end
        1: op.jt = 3'($urandom_range(0, 7));
        2: begin op.mem_wr = 1'b1; op.alu = $urandom & 32'h7FF; end
        default: begin op.ld = 1'b1; op.reg_wr = 1'b1; op.alu = $urandom & 32'h7FF; end
      endcase
      model(op, m);
      run_op(op, int'($urandom_range(0, 3)), r);
      cmp_res($sformatf("rnd%0d", t), r, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
